axi_lite_arbiter: RTL

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU = m0, LSU = m1) to one-slave AXI-Lite arbiter.
// A registered round-robin grant owns the slave until its R or B response completes.
module axi_lite_arbiter (
    input  logic        clk,
    input  logic        rst,
    // master 0 (IFU)
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m0_awaddr,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic [1:0]  m0_bresp,
    output logic        m0_bvalid,
    input  logic        m0_bready,
    // master 1 (LSU)
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [1:0]  m1_bresp,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    // slave
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_prio;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;

    logic        w_req0, w_req1, w_gnt, w_gnt_ar;
    logic        w_rd, w_wr;
    logic [31:0] w_own_araddr, w_own_awaddr, w_own_wdata;
    logic [3:0]  w_own_wstrb;
    logic        w_own_arvalid, w_own_rready, w_own_awvalid, w_own_wvalid, w_own_bready;

    assign w_req0   = m0_arvalid | (m0_awvalid & m0_wvalid);
    assign w_req1   = m1_arvalid | (m1_awvalid & m1_wvalid);
    assign w_gnt    = (w_req0 & w_req1) ? r_prio : w_req1;
    // A pending read wins over the same master's pending write.
    assign w_gnt_ar = w_gnt ? m1_arvalid : m0_arvalid;

    assign w_rd = (r_state == READ);
    assign w_wr = (r_state == WRITE);

    assign w_own_araddr  = r_owner ? m1_araddr  : m0_araddr;
    assign w_own_arvalid = r_owner ? m1_arvalid : m0_arvalid;
    assign w_own_rready  = r_owner ? m1_rready  : m0_rready;
    assign w_own_awaddr  = r_owner ? m1_awaddr  : m0_awaddr;
    assign w_own_awvalid = r_owner ? m1_awvalid : m0_awvalid;
    assign w_own_wdata   = r_owner ? m1_wdata   : m0_wdata;
    assign w_own_wstrb   = r_owner ? m1_wstrb   : m0_wstrb;
    assign w_own_wvalid  = r_owner ? m1_wvalid  : m0_wvalid;
    assign w_own_bready  = r_owner ? m1_bready  : m0_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_owner   <= w_gnt;
                        r_prio    <= ~w_gnt;
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= w_gnt_ar ? READ : WRITE;
                    end
                end
                READ: begin
                    if (s_arvalid & s_arready) r_ar_done <= 1'b1;
                    if (s_rvalid & w_own_rready) r_state <= IDLE;
                end
                WRITE: begin
                    if (s_awvalid & s_awready) r_aw_done <= 1'b1;
                    if (s_wvalid & s_wready)   r_w_done  <= 1'b1;
                    if (s_bvalid & w_own_bready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m0_arready = 1'b0; m0_rdata = '0; m0_rresp = '0; m0_rvalid = 1'b0;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bresp = '0; m0_bvalid = 1'b0;
        m1_arready = 1'b0; m1_rdata = '0; m1_rresp = '0; m1_rvalid = 1'b0;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_bresp = '0; m1_bvalid = 1'b0;

        if (w_rd) begin
            s_araddr  = w_own_araddr;
            s_arvalid = w_own_arvalid & ~r_ar_done;
            s_rready  = w_own_rready;
            if (r_owner) begin
                m1_arready = s_arready & ~r_ar_done;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
            end else begin
                m0_arready = s_arready & ~r_ar_done;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
            end
        end

        // AW and W complete independently; each channel goes quiet once its handshake is done.
        if (w_wr) begin
            s_awaddr  = w_own_awaddr;
            s_awvalid = w_own_awvalid & ~r_aw_done;
            s_wdata   = w_own_wdata;
            s_wstrb   = w_own_wstrb;
            s_wvalid  = w_own_wvalid & ~r_w_done;
            s_bready  = w_own_bready;
            if (r_owner) begin
                m1_awready = s_awready & ~r_aw_done;
                m1_wready  = s_wready & ~r_w_done;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
            end else begin
                m0_awready = s_awready & ~r_aw_done;
                m0_wready  = s_wready & ~r_w_done;
                m0_bresp   = s_bresp;
                m0_bvalid  = s_bvalid;
            end
        end
    end

endmodule
